// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle MIPS sequencer (master)
// and the datapath (slave).
// Optional build macro: MULTICYCLE_ILLEGAL_TRAP_EN adds the illegal_op flag.
interface multicycle_control_if #(
  parameter int RETIRE_W = 32
);
  // status from datapath
  logic [5:0]          opcode;
  logic                zero;
  logic                mem_ready;
  // controls to datapath
  logic                pc_en;
  logic                iord;
  logic                memwrite;
  logic                irwrite;
  logic                regdst;
  logic                memtoreg;
  logic                regwrite;
  logic                alusrca;
  logic [1:0]          alusrcb;
  logic [1:0]          aluop;
  logic [1:0]          pcsrc;
  // debug / bookkeeping
  logic [3:0]          state;
  logic [RETIRE_W-1:0] retire_cnt;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic                illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, state, retire_cnt, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, state, retire_cnt, illegal_op
  );
`else
  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, state, retire_cnt
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, state, retire_cnt
  );
`endif
endinterface

// File: rtl/multicycle_control.sv
// Main sequencer for the multi-cycle MIPS datapath (Moore FSM, memory
// states stall on mem_ready).
// Optional build macro: MULTICYCLE_ILLEGAL_TRAP_EN -- unsupported opcodes
// lock the FSM in TRAP and raise illegal_op; otherwise they retire as NOPs.
//
// state   | code | meaning
// IDLE    | 0    | first cycle after reset
// FETCH   | 1    | read instruction at PC, PC+4 on mem_ready
// DECODE  | 2    | register read, branch target precompute
// MEMADR  | 3    | lw/sw effective address
// MEMRD   | 4    | data read, waits for mem_ready
// MEMWB   | 5    | MDR -> rt
// MEMWR   | 6    | data write, memwrite held until mem_ready
// EXECUTE | 7    | R-type ALU op
// ALUWB   | 8    | ALUOut -> rd
// BRANCH  | 9    | beq compare, PC <- ALUOut if zero
// IMMEXEC | 10   | immediate ALU op
// IMMWB   | 11   | ALUOut -> rt
// JUMP    | 12   | PC <- jump target
// TRAP    | 13   | illegal opcode lock (trap build only)
module multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_IMMEXEC = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retire_cnt_q, retire_cnt_d;

  logic       pcwrite, branch, retire;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-state controls; everything defaults to 0.
  always_comb begin
    state_d  = state_q;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    retire   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        alusrcb = 2'b01;
        // IR and PC must load only on the cycle the fetch completes.
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = S_EXECUTE;
          OP_BEQ:                            state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEXEC;
          OP_J:                              state_d = S_JUMP;
          default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
            retire  = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_IMMEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Retire count advances on the same edge that returns to FETCH.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (retire) retire_cnt_d = retire_cnt_q + RETIRE_W'(1);
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retire_cnt_q <= '0;
    else          retire_cnt_q <= retire_cnt_d;
  end

  assign bus.pc_en      = pcwrite | (branch & bus.zero);
  assign bus.iord       = iord;
  assign bus.memwrite   = memwrite;
  assign bus.irwrite    = irwrite;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.aluop      = aluop;
  assign bus.pcsrc      = pcsrc;
  assign bus.state      = state_q;
  assign bus.retire_cnt = retire_cnt_q;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign bus.illegal_op = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if #(.RETIRE_W(32)) bus ();
  multicycle_control #(.RETIRE_W(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));

  // narrow counter instance to reach the wrap boundary quickly
  multicycle_control_if #(.RETIRE_W(2)) bus2 ();
  multicycle_control #(.RETIRE_W(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2.master));

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] ILL  = 6'b111111;

  // {pc_en,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,aluop,pcsrc}
  localparam logic [13:0] C_ZERO   = 14'b0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [13:0] C_FETCH  = 14'b1_0_0_1_0_0_0_0_01_00_00;
  localparam logic [13:0] C_FSTALL = 14'b0_0_0_0_0_0_0_0_01_00_00;
  localparam logic [13:0] C_DEC    = 14'b0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [13:0] C_MADR   = 14'b0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [13:0] C_MRD    = 14'b0_1_0_0_0_0_0_0_00_00_00;
  localparam logic [13:0] C_MWB    = 14'b0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [13:0] C_MWR    = 14'b0_1_1_0_0_0_0_0_00_00_00;
  localparam logic [13:0] C_EXEC   = 14'b0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [13:0] C_ALUWB  = 14'b0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [13:0] C_IMMEX  = 14'b0_0_0_0_0_0_0_1_10_11_00;
  localparam logic [13:0] C_IMMWB  = 14'b0_0_0_0_0_0_1_0_00_00_00;
  localparam logic [13:0] C_BR_T   = 14'b1_0_0_0_0_0_0_1_00_01_01;
  localparam logic [13:0] C_BR_N   = 14'b0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [13:0] C_JUMP   = 14'b1_0_0_0_0_0_0_0_00_00_10;

  typedef struct {
    logic [5:0]  opc;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [13:0] ctrl;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [13:0] ctrl_now();
    return {bus.pc_en, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
            bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic z, input logic r, input logic [3:0] s,
                     input logic [13:0] c, input logic [31:0] n);
    vec_t v;
    v.opc = o; v.z = z; v.rdy = r; v.st = s; v.ctrl = c; v.ret = n;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, queue its expectation, compare mid-cycle.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    bus.opcode    = v.opc;
    bus.zero      = v.z;
    bus.mem_ready = v.rdy;
    sb.push_back(v);
    #2;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " state"}, 32'(bus.state), 32'(e.st));
      check({tag, " ctrl"}, 32'(ctrl_now()), 32'(e.ctrl));
      check({tag, " retire"}, bus.retire_cnt, e.ret);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      check({tag, " illegal_op"}, 32'(bus.illegal_op), 32'(e.st == 4'd13));
`endif
    end
  endtask

  task automatic hstep(input logic [5:0] o, input logic z, input logic r, input logic [3:0] s,
                       input logic [13:0] c, input logic [31:0] n, input string tag);
    vec_t v;
    v.opc = o; v.z = z; v.rdy = r; v.st = s; v.ctrl = c; v.ret = n;
    step(v, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opcode = RT; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    bus2.opcode = J; bus2.zero = 1'b0; bus2.mem_ready = 1'b1;

    // R-type, then lw with 3 stall cycles
    add(RT,0,1, 0, C_ZERO,  0);
    add(RT,0,1, 1, C_FETCH, 0);
    add(RT,0,1, 2, C_DEC,   0);
    add(RT,0,1, 7, C_EXEC,  0);
    add(RT,0,1, 8, C_ALUWB, 0);
    add(LW,0,1, 1, C_FETCH, 1);
    add(LW,0,1, 2, C_DEC,   1);
    add(LW,0,1, 3, C_MADR,  1);
    add(LW,0,0, 4, C_MRD,   1);
    add(LW,0,0, 4, C_MRD,   1);
    add(LW,0,0, 4, C_MRD,   1);
    add(LW,0,1, 4, C_MRD,   1);
    add(LW,0,1, 5, C_MWB,   1);
    // fetch stall, then sw
    add(SW,0,0, 1, C_FSTALL,2);
    add(SW,0,1, 1, C_FETCH, 2);
    add(SW,0,1, 2, C_DEC,   2);
    add(SW,0,1, 3, C_MADR,  2);
    add(SW,0,1, 6, C_MWR,   2);
    // beq taken / not taken
    add(BEQ,1,1, 1, C_FETCH,3);
    add(BEQ,1,1, 2, C_DEC,  3);
    add(BEQ,1,1, 9, C_BR_T, 3);
    add(BEQ,0,1, 1, C_FETCH,4);
    add(BEQ,0,1, 2, C_DEC,  4);
    add(BEQ,0,1, 9, C_BR_N, 4);
    // addi, j, andi, ori, slti
    add(ADDI,0,1, 1, C_FETCH,5);
    add(ADDI,0,1, 2, C_DEC,  5);
    add(ADDI,0,1,10, C_IMMEX,5);
    add(ADDI,0,1,11, C_IMMWB,5);
    add(J,0,1,    1, C_FETCH,6);
    add(J,0,1,    2, C_DEC,  6);
    add(J,0,1,   12, C_JUMP, 6);
    add(ANDI,0,1, 1, C_FETCH,7);
    add(ANDI,0,1, 2, C_DEC,  7);
    add(ANDI,0,1,10, C_IMMEX,7);
    add(ANDI,0,1,11, C_IMMWB,7);
    add(ORI,0,1,  1, C_FETCH,8);
    add(ORI,0,1,  2, C_DEC,  8);
    add(ORI,0,1, 10, C_IMMEX,8);
    add(ORI,0,1, 11, C_IMMWB,8);
    add(SLTI,0,1, 1, C_FETCH,9);
    add(SLTI,0,1, 2, C_DEC,  9);
    add(SLTI,0,1,10, C_IMMEX,9);
    add(SLTI,0,1,11, C_IMMWB,9);
    add(SW,0,1,   1, C_FETCH,10);

    // reset state, with mem_ready high so irwrite/pc_en must still be 0
    @(negedge clk); #2;
    check("reset state", 32'(bus.state), 32'd0);
    check("reset ctrl", 32'(ctrl_now()), 32'(C_ZERO));
    check("reset retire", bus.retire_cnt, 32'd0);

    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // sw stalled in MEMWR, then reset mid-stall
    hstep(SW,0,1, 2, C_DEC,  10, "sw dec");
    hstep(SW,0,1, 3, C_MADR, 10, "sw adr");
    hstep(SW,0,0, 6, C_MWR,  10, "sw stall0");
    hstep(SW,0,0, 6, C_MWR,  10, "sw stall1");
    #1 reset_n = 1'b0;
    #1;
    check("midreset memwrite", 32'(bus.memwrite), 32'd0);
    check("midreset state", 32'(bus.state), 32'd0);
    check("midreset ctrl", 32'(ctrl_now()), 32'(C_ZERO));
    check("midreset retire", bus.retire_cnt, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // unsupported opcode
    hstep(ILL,0,1, 0, C_ZERO,  0, "ill idle");
    hstep(ILL,0,1, 1, C_FETCH, 0, "ill fetch");
    hstep(ILL,0,1, 2, C_DEC,   0, "ill dec");
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    hstep(ILL,0,1, 13, C_ZERO, 0, "trap0");
    hstep(RT,1,1,  13, C_ZERO, 0, "trap1");
    hstep(LW,0,1,  13, C_ZERO, 0, "trap2");
    #1 reset_n = 1'b0;
    #1;
    check("trap reset illegal_op", 32'(bus.illegal_op), 32'd0);
    check("trap reset state", 32'(bus.state), 32'd0);
`else
    hstep(RT,0,1, 1, C_FETCH, 1, "nop fetch");
    hstep(RT,0,1, 2, C_DEC,   1, "nop dec");
    #1 reset_n = 1'b0;
`endif

    // retire counter wrap on the 2-bit instance running back-to-back jumps
    @(negedge clk); #2;
    check("wrap reset retire", 32'(bus2.retire_cnt), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk); #2;
      if (k == 0)  check("wrap k0 state", 32'(bus2.state), 32'd0);
      if (k == 4)  check("wrap k4", 32'(bus2.retire_cnt), 32'd1);
      if (k == 10) check("wrap k10", 32'(bus2.retire_cnt), 32'd3);
      if (k == 12) check("wrap k12", 32'(bus2.retire_cnt), 32'd3);
      if (k == 13) check("wrap k13", 32'(bus2.retire_cnt), 32'd0);
      if (k == 16) check("wrap k16", 32'(bus2.retire_cnt), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main sequencer for the multi-cycle MIPS datapath: one shared ALU, one unified instruction/data memory, IR and PC registers.
- Moore FSM; each instruction takes 3–5 states, and memory states stall on a ready handshake.
- Drives the datapath mux selects and write enables, the ALU decoder op class, and an instruction-retire counter.
- Supported instructions: R-type, lw, sw, beq, addi, andi, ori, slti, j.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter (wraps modulo 2^RETIRE_W).

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; sampled only in DECODE and MEMADR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_en  out  1  PC load enable = pcwrite | (branch & zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  IR load enable.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = MDR, 0 = ALUOut.
- regwrite  out  1  register-file write enable.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- aluop  out  2  00 = add, 01 = sub, 10 = use funct, 11 = use opcode (immediate ops).
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding, for debug.
- retire_cnt  out  RETIRE_W  count of completed instructions.
- illegal_op  out  1  only exists with the optional feature.

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE (0), retire_cnt = 0.
  - Every output not listed for the current state is 0, so all enables are 0 during reset.
  - Reset mid-instruction aborts immediately; there is no partial write-back.
- State encodings:
  - IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6
  - EXECUTE 7, ALUWB 8, BRANCH 9, IMMEXEC 10, IMMWB 11, JUMP 12, TRAP 13.
- Per-state outputs and transitions:
  - IDLE: all outputs 0. Next state FETCH unconditionally.
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
    - irwrite = pcwrite = mem_ready; these are the only Mealy-qualified outputs.
    - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by opcode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000, 001100, 001101, 001010 -> IMMEXEC
    - 000010 -> JUMP
    - any other opcode -> see Optional Feature.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: iord=1. Waits for mem_ready, then -> MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. -> FETCH.
  - MEMWR: iord=1, memwrite=1.
    - memwrite stays held until the mem_ready cycle, then -> FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10. -> ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1. -> FETCH.
  - IMMEXEC: alusrca=1, alusrcb=10, aluop=11. -> IMMWB.
  - IMMWB: regdst=0, memtoreg=0, regwrite=1. -> FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. -> FETCH.
  - JUMP: pcsrc=10, pcwrite=1. -> FETCH.
- Retire counter: increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, IMMWB, BRANCH or JUMP.
  - Counts in the same edge as the transition.
  - Wraps from all-ones to 0.
- Latency in cycles, counted from the FETCH mem_ready cycle to return to FETCH, with mem_ready held 1:
  - R-type / immediate: 4
  - lw: 5
  - sw: 4
  - beq / j: 3
  - Each stalled memory cycle adds 1.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported opcode in DECODE -> TRAP. In TRAP all enables are 0 and illegal_op=1.
  - The FSM stays in TRAP until reset; illegal_op resets to 0.
  - The illegal instruction is not counted in retire_cnt.
- Not defined:
  - The illegal_op port is absent.
  - An unsupported opcode is treated as a NOP: DECODE -> FETCH, and retire_cnt increments.

Test Plan:
- Reset release, mem_ready=1, opcode=000000 -> state sequence 0,1,2,7,8,1. regwrite=1 with regdst=1 only in ALUWB. retire_cnt=1.
- lw (100011) with mem_ready=0 for 3 cycles in MEMRD -> iord=1 for 4 cycles. MEMWB asserts memtoreg=1, regwrite=1. Total 8 cycles from FETCH back to FETCH.
- sw (101011), mem_ready=1 -> memwrite=1 exactly 1 cycle, in state 6. regwrite never asserted.
- beq with zero=1 -> pc_en=1 and pcsrc=01 in BRANCH. With zero=0 -> pc_en=0 in BRANCH.
- addi, then j -> IMMEXEC has aluop=11 and alusrcb=10. JUMP has pcsrc=10 and pc_en=1. retire_cnt goes 0->1->2.
- Opcode 111111: with macro -> state 13, illegal_op=1, retire_cnt unchanged. Without macro -> back to FETCH, retire_cnt+1. Asserting reset_n=0 in MEMWR mid-stall -> memwrite=0 immediately and state=0.
